// File: rtl/k12a_lcd_pkg.sv
// k12a_lcd_pkg: shared types, constants and helpers for the k12a LCD write sequencer.
// Provides the sequencer state enum, the power-up command ROM, status bit indices,
// the clear/home long-delay predicate and a constant max helper for sizing the timer.
package k12a_lcd_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, ENABLE, HOLD, WAIT, INIT_WAIT} state_t;
    localparam int STATUS_BUSY = 0;
    localparam int STATUS_FULL = 1;
    localparam int STATUS_OVF  = 2;
    localparam int INIT_LEN = 6;
    // Byte 0 sits in the low bits: 38,38,38,0C,01,06 in issue order
    localparam logic [8*INIT_LEN-1:0] INIT_SEQ = {8'h06, 8'h01, 8'h0C, 8'h38, 8'h38, 8'h38};
    // Clear display (01) and return home (02/03) need the long execution wait
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && data[7:2] == 6'h00 && data != 8'h00;
    endfunction
    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/k12a_lcd_ctrl_if.sv
// k12a_lcd_ctrl_if: CPU-side push/status bus plus the panel pins of the LCD sequencer.
// master: drives push, push_rs, push_data, clear_overflow; observes status and lcd_* pins.
// slave:  the sequencer; samples the push side and drives status and lcd_* pins.
interface k12a_lcd_ctrl_if;
    logic       push;
    logic       push_rs;
    logic [7:0] push_data;
    logic       clear_overflow;
    logic [7:0] status;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_data;
    modport master (
        output push, push_rs, push_data, clear_overflow,
        input  status, lcd_rs, lcd_rw, lcd_en, lcd_data
    );
    modport slave (
        input  push, push_rs, push_data, clear_overflow,
        output status, lcd_rs, lcd_rw, lcd_en, lcd_data
    );
endinterface

// File: rtl/k12a_lcd_fifo.sv
// k12a_lcd_fifo: synchronous FIFO, DEPTH a power of two; caller must not push when full or pop when empty.
// Ports: clk, rst (sync, active-high), push/din, pop/dout (show-ahead head), count, full, empty.
module k12a_lcd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    assign dout  = mem[rd_ptr];
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/k12a_lcd_ctrl.sv
// k12a_lcd_ctrl: HD44780 write sequencer replaying FIFO'd {rs,data} bytes as timed LCD write cycles.
// Ports: cpu_clock; reset (sync, active-high); bus (slave) carrying push/push_rs/push_data/clear_overflow
//        in and status {5'h0,overflow,full,busy}, lcd_rs, lcd_rw (tied 0), lcd_en, lcd_data out.
// Build option: K12A_LCD_INIT_EN makes reset wait INIT_DELAY_CYCLES and then replay the panel
//        power-up commands from ROM before draining the FIFO.
module k12a_lcd_ctrl
    import k12a_lcd_pkg::*;
#(
    parameter int FIFO_DEPTH        = 4,
    parameter int SETUP_CYCLES      = 2,
    parameter int EN_CYCLES         = 12,
    parameter int HOLD_CYCLES       = 2,
    parameter int CMD_DELAY_CYCLES  = 2000,
    parameter int LONG_DELAY_CYCLES = 80000,
    parameter int INIT_DELAY_CYCLES = 200000
) (
    input  logic           cpu_clock,
    input  logic           reset,
    k12a_lcd_ctrl_if.slave bus
);
    localparam int MAXD = max2(max2(max2(SETUP_CYCLES, EN_CYCLES), max2(HOLD_CYCLES, CMD_DELAY_CYCLES)),
                               max2(LONG_DELAY_CYCLES, INIT_DELAY_CYCLES));
    localparam int TW = $clog2(MAXD) + 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    // Each state runs for N cycles: timer is loaded with N-1 on entry and the state exits at zero
    localparam logic [TW-1:0] T_SETUP = TW'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0] T_EN    = TW'(EN_CYCLES - 1);
    localparam logic [TW-1:0] T_HOLD  = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] T_CMD   = TW'(CMD_DELAY_CYCLES - 1);
    localparam logic [TW-1:0] T_LONG  = TW'(LONG_DELAY_CYCLES - 1);
    localparam logic [TW-1:0] T_INIT  = TW'(INIT_DELAY_CYCLES - 1);
    state_t          state;
    logic [TW-1:0]   timer;
    logic            overflow, lcd_rs, lcd_en, full, empty, pop;
    logic [7:0]      lcd_data;
    logic [8:0]      head;
    logic [CW-1:0]   count;
`ifdef K12A_LCD_INIT_EN
    logic [2:0]      init_idx;
`endif
    assign pop          = state == IDLE && !empty;
    assign bus.lcd_rs   = lcd_rs;
    assign bus.lcd_rw   = 1'b0;
    assign bus.lcd_en   = lcd_en;
    assign bus.lcd_data = lcd_data;
    always_comb begin
        bus.status              = 8'h00;
        bus.status[STATUS_BUSY] = state != IDLE || count != '0;
        bus.status[STATUS_FULL] = full;
        bus.status[STATUS_OVF]  = overflow;
    end
    // A push while full is dropped here, even if the sequencer pops in the same cycle
    k12a_lcd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(9)) fifo (
        .clk   (cpu_clock),
        .rst   (reset),
        .push  (bus.push && !full),
        .pop   (pop),
        .din   ({bus.push_rs, bus.push_data}),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );
    always_ff @(posedge cpu_clock) begin
        if (reset) begin
`ifdef K12A_LCD_INIT_EN
            state    <= INIT_WAIT;
            timer    <= T_INIT;
            init_idx <= 3'd0;
`else
            state    <= IDLE;
            timer    <= '0;
`endif
            overflow <= 1'b0;
            lcd_en   <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
        end else begin
            // An overflowing push beats a simultaneous clear
            overflow <= (bus.push && full) || (overflow && !bus.clear_overflow);
            if (timer != '0) begin
                timer <= timer - 1'b1;
            end else begin
                case (state)
                    IDLE: if (!empty) begin
                        {lcd_rs, lcd_data} <= head;
                        state              <= SETUP;
                        timer              <= T_SETUP;
                    end
                    SETUP: begin
                        state  <= ENABLE;
                        timer  <= T_EN;
                        lcd_en <= 1'b1;
                    end
                    ENABLE: begin
                        state  <= HOLD;
                        timer  <= T_HOLD;
                        lcd_en <= 1'b0;
                    end
                    HOLD: begin
                        state <= WAIT;
                        timer <= is_long_cmd(lcd_rs, lcd_data) ? T_LONG : T_CMD;
                    end
`ifdef K12A_LCD_INIT_EN
                    // Power-up wait and every init write's WAIT both fall through to the next ROM byte
                    WAIT, INIT_WAIT: if (init_idx != 3'(INIT_LEN)) begin
                        {lcd_rs, lcd_data} <= {1'b0, INIT_SEQ[{init_idx, 3'b000} +: 8]};
                        init_idx           <= init_idx + 3'd1;
                        state              <= SETUP;
                        timer              <= T_SETUP;
                    end else begin
                        state <= IDLE;
                    end
`else
                    WAIT: state <= IDLE;
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
